sdr_app_arbiter: RTL
====================

// Module: sdr_app_arbiter
// PURPOSE
//  Shares the single SDRAM-controller application port (app_req/addr/len/wr_n/wrap/wr_data/wr_en_n)
//  between NREQ requesters. Round-robin, one transaction in flight; grant held from request to last beat.
//  Routes ack, write-data-next, read data/valid and last strobes back to the granted requester.
//  Sits between the client masters and the SDRAM controller application interface.
// PARAMETERS
//  NREQ     4    number of requesters (2..8)
//  APP_AW   26   application address width
//  APP_DW   32   application data width
//  APP_BW   4    application byte-enable width
//  APP_RW   9    burst length width (units of APP_DW words)
//  TMO_W    12   watchdog counter width; timeout at 2**TMO_W-1 cycles
// PORTS
//  sdram_clk        in   1            SDRAM clock; the block's only clock
//  reset            in   1            synchronous, active-high reset
//  cfg_sdr_en       in   1            controller enabled; no new grant while low
//  sdr_init_done    in   1            SDRAM init complete; no new grant while low
//  req_valid        in   NREQ         per-requester request
//  req_addr         in   NREQ*APP_AW  per-requester address, slice i = requester i
//  req_len          in   NREQ*APP_RW  per-requester burst length
//  req_wr_n         in   NREQ         0 write, 1 read
//  req_wrap         in   NREQ         address wrap
//  req_wr_data      in   NREQ*APP_DW  per-requester write data
//  req_wr_en_n      in   NREQ*APP_BW  per-requester byte write enable (active low)
//  req_ack          out  NREQ         request accepted
//  req_wr_next      out  NREQ         next write word taken
//  req_rd_valid     out  NREQ         read word valid (data on req_rd_data)
//  req_rd_data      out  APP_DW       read data, broadcast to all requesters
//  req_last_rd      out  NREQ         last read word
//  req_last_wr      out  NREQ         last write word
//  app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_wrap   out   to controller (registered)
//  app_wr_data [APP_DW], app_wr_en_n [APP_BW]                       out   to controller (comb. mux)
//  app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd, app_last_wr in 1; app_rd_data in APP_DW
//  grant            out  NREQ         one-hot current owner, 0 when idle
//  err_timeout      out  1            sticky watchdog error
// BEHAVIOUR
//  Reset: state IDLE; app_req, app_req_* fields, grant, err_timeout, counter = 0; RR pointer = NREQ-1.
//  FSM IDLE -> REQ -> WR_DATA | RD_DATA -> IDLE.
//  IDLE: eligible = req_valid & cfg_sdr_en & sdr_init_done. Winner = first set bit scanning from ptr+1
//   modulo NREQ. Next edge: grant=onehot(winner), app_req=1, app_req_* latched from winner slice, -> REQ.
//   Winner with req_len==0: no app_req; req_ack[w] pulses 1 cycle, ptr=w, stay IDLE.
//  REQ: app_req and fields held stable until app_req_ack=1. req_ack[g]=app_req_ack (comb.). On ack edge:
//   app_req=0, -> WR_DATA if wr_n=0 else RD_DATA. Ack in first REQ cycle allowed (1-cycle request).
//  WR_DATA/REQ: app_wr_data/app_wr_en_n = granted slice (comb.); req_wr_next[g]=app_wr_next_req.
//   app_last_wr=1 -> IDLE next edge, ptr=g, grant=0.
//  RD_DATA: req_rd_valid[g]=app_rd_valid, req_last_rd[g]=app_last_rd, req_rd_data=app_rd_data.
//   app_rd_valid & app_last_rd -> IDLE, ptr=g, grant=0.
//  Non-granted bits of all per-requester outputs are 0. When grant=0, app_wr_data=0, app_wr_en_n=all 1.
//  Earliest re-grant: cycle after completion (one idle cycle between transactions).
//  cfg_sdr_en/sdr_init_done falling mid-transaction: transaction runs to completion; only new grants blocked.
//  req_valid dropping after grant: ignored; transaction still completes.
//  Watchdog: counter clears on entry to REQ; increments each cycle outside IDLE; at all-ones sets
//   err_timeout (sticky until reset); no abort. Counter saturates.
//  reset mid-transaction: everything returns to reset values on next edge regardless of state.
// TESTING
//  T1 reset, all req_valid=4'b1111, ack after 2 cycles, len=1 writes -> grants in order 0,1,2,3,0.
//  T2 req1 write len=4 addr=0x100; app_wr_next_req 4 cycles -> app_wr_data follows req1 slice, req_wr_next=4'b0010.
//  T3 req2 read len=8; 8 app_rd_valid, last on 8th -> req_rd_valid[2] x8, req_last_rd[2] once, then IDLE.
//  T4 sdr_init_done=0 with req_valid=4'b0001 -> app_req stays 0; raise init_done -> app_req=1 next edge.
//  T5 req3 len=0 -> req_ack[3] 1-cycle pulse, app_req never asserts, ptr=3 (next winner 0 if pending).
//  T6 reset asserted in RD_DATA, TMO_W=4 stall run -> all outputs reset; stalled run sets err_timeout.

Source files
------------

// File: rtl/sdr_app_arbiter_if.sv
// Requester-side and controller-side application port bundles for sdr_app_arbiter.
// Per-requester fields are flat vectors; slice i belongs to requester i.
interface sdr_req_if #(
  parameter int NREQ   = 4,
  parameter int APP_AW = 26,
  parameter int APP_DW = 32,
  parameter int APP_BW = 4,
  parameter int APP_RW = 9
) ();
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*APP_AW-1:0] req_addr;
  logic [NREQ*APP_RW-1:0] req_len;
  logic [NREQ-1:0]        req_wr_n;
  logic [NREQ-1:0]        req_wrap;
  logic [NREQ*APP_DW-1:0] req_wr_data;
  logic [NREQ*APP_BW-1:0] req_wr_en_n;
  logic [NREQ-1:0]        req_ack;
  logic [NREQ-1:0]        req_wr_next;
  logic [NREQ-1:0]        req_rd_valid;
  logic [APP_DW-1:0]      req_rd_data;
  logic [NREQ-1:0]        req_last_rd;
  logic [NREQ-1:0]        req_last_wr;

  modport master (
    output req_valid, req_addr, req_len, req_wr_n, req_wrap, req_wr_data, req_wr_en_n,
    input  req_ack, req_wr_next, req_rd_valid, req_rd_data, req_last_rd, req_last_wr
  );
  modport slave (
    input  req_valid, req_addr, req_len, req_wr_n, req_wrap, req_wr_data, req_wr_en_n,
    output req_ack, req_wr_next, req_rd_valid, req_rd_data, req_last_rd, req_last_wr
  );
endinterface

interface sdr_app_if #(
  parameter int APP_AW = 26,
  parameter int APP_DW = 32,
  parameter int APP_BW = 4,
  parameter int APP_RW = 9
) ();
  logic              app_req;
  logic [APP_AW-1:0] app_req_addr;
  logic [APP_RW-1:0] app_req_len;
  logic              app_req_wr_n;
  logic              app_req_wrap;
  logic [APP_DW-1:0] app_wr_data;
  logic [APP_BW-1:0] app_wr_en_n;
  logic              app_req_ack;
  logic              app_wr_next_req;
  logic              app_rd_valid;
  logic [APP_DW-1:0] app_rd_data;
  logic              app_last_rd;
  logic              app_last_wr;

  modport master (
    output app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_wrap, app_wr_data, app_wr_en_n,
    input  app_req_ack, app_wr_next_req, app_rd_valid, app_rd_data, app_last_rd, app_last_wr
  );
  modport slave (
    input  app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_wrap, app_wr_data, app_wr_en_n,
    output app_req_ack, app_wr_next_req, app_rd_valid, app_rd_data, app_last_rd, app_last_wr
  );
endinterface

// File: rtl/sdr_app_arbiter.sv
// Round-robin owner of the SDRAM application port: request registered (1 cycle after pick),
// data/ack paths combinational; one transaction in flight, grant held until the last beat.
module sdr_app_arbiter #(
  parameter int NREQ   = 4,
  parameter int APP_AW = 26,
  parameter int APP_DW = 32,
  parameter int APP_BW = 4,
  parameter int APP_RW = 9,
  parameter int TMO_W  = 12
) (
  input  logic            sdram_clk,
  input  logic            reset,
  input  logic            cfg_sdr_en,
  input  logic            sdr_init_done,
  sdr_req_if.slave        req,
  sdr_app_if.master       app,
  output logic [NREQ-1:0] grant,
  output logic            err_timeout
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WR_DATA, RD_DATA} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, gnt_idx, win_idx;
  logic             win_vld, win_zero;
  logic [NREQ-1:0]  eligible, win_oh;
  logic [TMO_W-1:0] tmo_cnt;

  assign eligible = req.req_valid & {NREQ{cfg_sdr_en & sdr_init_done}};
  assign win_oh   = NREQ'(1) << win_idx;
  assign win_zero = (req.req_len[win_idx*APP_RW +: APP_RW] == '0);

  // Scan starts just after the last served requester, so it becomes lowest priority.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!win_vld && eligible[(int'(ptr) + i) % NREQ]) begin
        win_vld = 1'b1;
        win_idx = PW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld && !win_zero) state_nxt = REQ;
      REQ:     if (app.app_req_ack) state_nxt = app.app_req_wr_n ? RD_DATA : WR_DATA;
      WR_DATA: if (app.app_last_wr) state_nxt = IDLE;
      RD_DATA: if (app.app_rd_valid && app.app_last_rd) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= PW'(NREQ - 1);
      gnt_idx          <= '0;
      grant            <= '0;
      app.app_req      <= 1'b0;
      app.app_req_addr <= '0;
      app.app_req_len  <= '0;
      app.app_req_wr_n <= 1'b0;
      app.app_req_wrap <= 1'b0;
      tmo_cnt          <= '0;
      err_timeout      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (win_vld && win_zero) begin
            ptr <= win_idx;
          end else if (win_vld) begin
            grant            <= win_oh;
            gnt_idx          <= win_idx;
            app.app_req      <= 1'b1;
            app.app_req_addr <= req.req_addr[win_idx*APP_AW +: APP_AW];
            app.app_req_len  <= req.req_len[win_idx*APP_RW +: APP_RW];
            app.app_req_wr_n <= req.req_wr_n[win_idx];
            app.app_req_wrap <= req.req_wrap[win_idx];
          end
        end
        REQ: if (app.app_req_ack) app.app_req <= 1'b0;
        default: begin
          if (state_nxt == IDLE) begin
            ptr   <= gnt_idx;
            grant <= '0;
          end
        end
      endcase
      // Watchdog only flags a stuck controller; the transaction is never aborted.
      if (state == IDLE && state_nxt == REQ) tmo_cnt <= '0;
      else if (state != IDLE && tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (tmo_cnt == '1) err_timeout <= 1'b1;
    end
  end

  always_comb begin
    req.req_ack      = '0;
    req.req_wr_next  = '0;
    req.req_rd_valid = '0;
    req.req_last_rd  = '0;
    req.req_last_wr  = '0;
    req.req_rd_data  = app.app_rd_data;
    app.app_wr_data  = '0;
    app.app_wr_en_n  = '1;
    case (state)
      IDLE: if (win_vld && win_zero) req.req_ack = win_oh;
      REQ: begin
        req.req_ack     = grant & {NREQ{app.app_req_ack}};
        req.req_wr_next = grant & {NREQ{app.app_wr_next_req}};
      end
      WR_DATA: begin
        req.req_wr_next = grant & {NREQ{app.app_wr_next_req}};
        req.req_last_wr = grant & {NREQ{app.app_last_wr}};
      end
      RD_DATA: begin
        req.req_rd_valid = grant & {NREQ{app.app_rd_valid}};
        req.req_last_rd  = grant & {NREQ{app.app_last_rd}};
      end
      default: ;
    endcase
    if (grant != '0) begin
      app.app_wr_data = req.req_wr_data[gnt_idx*APP_DW +: APP_DW];
      app.app_wr_en_n = req.req_wr_en_n[gnt_idx*APP_BW +: APP_BW];
    end
  end
endmodule
